// File: rtl/cv32e40p_pkg2.sv
// Shared types and constants for the TMR fault-tolerance error manager.
package cv32e40p_pkg2;

    // Record kinds; numeric order is severity order, so "max" merges records.
    typedef enum logic [1:0] {
        KIND_NONE   = 2'b00,
        KIND_CORR   = 2'b01,
        KIND_UNCORR = 2'b10,
        KIND_BRK    = 2'b11
    } log_kind_e;

    typedef logic [1:0] ft_state_t;

    localparam ft_state_t ST_IDLE    = 2'd0;
    localparam ft_state_t ST_SELECT  = 2'd1;
    localparam ft_state_t ST_PRESENT = 2'd2;

    localparam logic [1:0] OP_NOP      = 2'b00;
    localparam logic [1:0] OP_SET_BRK  = 2'b01;
    localparam logic [1:0] OP_CLR_BRK  = 2'b10;
    localparam logic [1:0] OP_CLR_PEND = 2'b11;

    // Number of set bits in a 3-replica mask.
    function automatic logic [1:0] popcount3(input logic [2:0] v);
        popcount3 = {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/cv32e40p_ft_rr_arbiter.sv
// Combinational round-robin pick: first set bit of pend_i at or after ptr_i.
module cv32e40p_ft_rr_arbiter #(
    parameter int N_BLK = 8,
    parameter int IDX_W = $clog2(N_BLK)
) (
    input  logic [N_BLK-1:0] pend_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    logic [IDX_W-1:0] cand;

    // Scan N_BLK candidates starting at the pointer, wrapping at N_BLK.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        cand    = '0;
        for (int i = 0; i < N_BLK; i++) begin
            cand = IDX_W'((int'(ptr_i) + i) % N_BLK);
            if (!found_o && pend_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/cv32e40p_ft_error_manager.sv
// Central error manager for the TMR voter/breakage-monitor wrappers.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | accept config commands; start arbitration if any record pends
// ST_SELECT  | register the round-robin winner
// ST_PRESENT | drive the winning record on the log port until accepted
module cv32e40p_ft_error_manager
    import cv32e40p_pkg2::*;
#(
    parameter int N_BLK = 8,
    parameter int IDX_W = $clog2(N_BLK),
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_BLK-1:0]        err_detected_i,
    input  logic [N_BLK-1:0]        err_corrected_i,
    input  logic [N_BLK-1:0][2:0]   is_broken_i,
    output logic [N_BLK-1:0][2:0]   set_broken_o,
    output logic                    log_valid_o,
    input  logic                    log_ready_i,
    output logic [IDX_W-1:0]        log_blk_o,
    output logic [1:0]              log_kind_o,
    output logic [2:0]              log_replica_o,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [1:0]              cmd_op_i,
    input  logic [IDX_W-1:0]        cmd_blk_i,
    input  logic [2:0]              cmd_mask_i,
    output logic [CNT_W-1:0]        merge_cnt_o,
    output logic                    fatal_o
);

    ft_state_t                state_q, state_d;
    logic [N_BLK-1:0][2:0]    brk_q;
    logic [N_BLK-1:0][2:0]    new_brk;
    log_kind_e                ev_kind     [N_BLK];
    log_kind_e                pend_kind_q [N_BLK];
    logic [N_BLK-1:0][2:0]    pend_rep_q;
    logic [N_BLK-1:0][2:0]    set_broken_q;
    logic [N_BLK-1:0]         pend_vec;
    logic [N_BLK-1:0]         clr_vec;
    logic [N_BLK-1:0]         merge_vec;
    logic [IDX_W-1:0]         rr_ptr_q;
    logic [IDX_W-1:0]         sel_q;
    logic [IDX_W-1:0]         arb_idx;
    logic                     arb_found;
    logic                     cmd_acc;
    logic                     log_hs;
    logic                     cmd_blk_ok;
    logic [IDX_W:0]           merge_sum;
    logic [CNT_W:0]           cnt_ext;
    logic [CNT_W-1:0]         merge_cnt_q, merge_cnt_d;
    logic                     fatal_q, fatal_now;

    assign cmd_blk_ok = int'(cmd_blk_i) < N_BLK;

    cv32e40p_ft_rr_arbiter #(
        .N_BLK (N_BLK),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .pend_i  (pend_vec),
        .ptr_i   (rr_ptr_q),
        .idx_o   (arb_idx),
        .found_o (arb_found)
    );

    // Classify this cycle's event per block and decide clear / merge per record.
    always_comb begin
        new_brk   = '0;
        ev_kind   = '{default: KIND_NONE};
        pend_vec  = '0;
        clr_vec   = '0;
        merge_vec = '0;
        for (int b = 0; b < N_BLK; b++) begin
            new_brk[b] = is_broken_i[b] & ~brk_q[b];
            if (new_brk[b] != 3'b000)
                ev_kind[b] = KIND_BRK;
            else if (err_detected_i[b] && !err_corrected_i[b])
                ev_kind[b] = KIND_UNCORR;
            else if (err_detected_i[b])
                ev_kind[b] = KIND_CORR;
            pend_vec[b]  = pend_kind_q[b] != KIND_NONE;
            clr_vec[b]   = (log_hs && int'(sel_q) == b) ||
                           (cmd_acc && cmd_op_i == OP_CLR_PEND && int'(cmd_blk_i) == b);
            merge_vec[b] = pend_vec[b] && !clr_vec[b] && ev_kind[b] != KIND_NONE;
        end
    end

    // Saturating merge counter; several blocks may merge in one cycle.
    always_comb begin
        merge_sum = '0;
        for (int b = 0; b < N_BLK; b++)
            merge_sum = merge_sum + (IDX_W+1)'(merge_vec[b]);
        cnt_ext     = {1'b0, merge_cnt_q} + (CNT_W+1)'(merge_sum);
        merge_cnt_d = cnt_ext[CNT_W] ? '1 : cnt_ext[CNT_W-1:0];
    end

    // A block is fatal once two or more replicas are broken or forced broken.
    always_comb begin
        fatal_now = 1'b0;
        for (int b = 0; b < N_BLK; b++)
            if (popcount3(is_broken_i[b] | set_broken_q[b]) >= 2'd2)
                fatal_now = 1'b1;
    end

    // FSM next state; commands only in IDLE and they pre-empt logging.
    always_comb begin
        state_d = state_q;
        cmd_acc = 1'b0;
        log_hs  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i)
                    cmd_acc = 1'b1;
                else if (|pend_vec)
                    state_d = ST_SELECT;
            end
            ST_SELECT:  state_d = arb_found ? ST_PRESENT : ST_IDLE;
            ST_PRESENT: begin
                if (log_ready_i) begin
                    log_hs  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    // FSM state, selection register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_SELECT)
                sel_q <= arb_idx;
            if (log_hs)
                rr_ptr_q <= (int'(sel_q) == N_BLK-1) ? '0 : sel_q + 1'b1;
        end
    end

    // Pending records. The presented record stays live, so an event that lands
    // on it while waiting escalates what is shown instead of being dropped; on
    // the clearing cycle the record restarts from this cycle's event alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            brk_q       <= '0;
            pend_rep_q  <= '0;
            merge_cnt_q <= '0;
            for (int b = 0; b < N_BLK; b++)
                pend_kind_q[b] <= KIND_NONE;
        end else begin
            brk_q       <= is_broken_i;
            merge_cnt_q <= merge_cnt_d;
            for (int b = 0; b < N_BLK; b++) begin
                if (clr_vec[b]) begin
                    pend_kind_q[b] <= ev_kind[b];
                    pend_rep_q[b]  <= new_brk[b];
                end else begin
                    if (ev_kind[b] > pend_kind_q[b])
                        pend_kind_q[b] <= ev_kind[b];
                    pend_rep_q[b] <= pend_rep_q[b] | new_brk[b];
                end
            end
        end
    end

    // Replica force masks driven from accepted commands; fatal flag is sticky.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            set_broken_q <= '0;
            fatal_q      <= 1'b0;
        end else begin
            fatal_q <= fatal_q | fatal_now;
            if (cmd_acc && cmd_blk_ok) begin
                case (cmd_op_i)
                    OP_SET_BRK: set_broken_q[cmd_blk_i] <= set_broken_q[cmd_blk_i] | cmd_mask_i;
                    OP_CLR_BRK: set_broken_q[cmd_blk_i] <= 3'b000;
                    default:    ;
                endcase
            end
        end
    end

    assign set_broken_o  = set_broken_q;
    assign merge_cnt_o   = merge_cnt_q;
    assign fatal_o       = fatal_q;
    assign cmd_ready_o   = (state_q == ST_IDLE) && rst_n;
    assign log_valid_o   = (state_q == ST_PRESENT);
    assign log_blk_o     = log_valid_o ? sel_q : '0;
    assign log_kind_o    = log_valid_o ? pend_kind_q[sel_q] : 2'b00;
    assign log_replica_o = log_valid_o ? pend_rep_q[sel_q] : 3'b000;

endmodule

// File: tb/tb_cv32e40p_ft_error_manager.sv
// Scoreboard bench for the TMR error manager: directed events push expected
// log records, a negedge monitor pops and compares on every log handshake.
module tb_cv32e40p_ft_error_manager;

    localparam int N_BLK = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 8;

    typedef struct packed {
        logic [2:0] blk;
        logic [1:0] kind;
        logic [2:0] rep;
    } rec_t;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N_BLK-1:0]      det, corr;
    logic [N_BLK-1:0][2:0] brk, set_brk, exp_sb;
    logic                  log_valid, log_ready;
    logic [IDX_W-1:0]      log_blk;
    logic [1:0]            log_kind;
    logic [2:0]            log_rep;
    logic                  cmd_valid, cmd_ready;
    logic [1:0]            cmd_op;
    logic [IDX_W-1:0]      cmd_blk;
    logic [2:0]            cmd_mask;
    logic [CNT_W-1:0]      merge_cnt;
    logic                  fatal;

    rec_t exp_q[$];
    rec_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    cv32e40p_ft_error_manager #(
        .N_BLK (N_BLK),
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .err_detected_i  (det),
        .err_corrected_i (corr),
        .is_broken_i     (brk),
        .set_broken_o    (set_brk),
        .log_valid_o     (log_valid),
        .log_ready_i     (log_ready),
        .log_blk_o       (log_blk),
        .log_kind_o      (log_kind),
        .log_replica_o   (log_rep),
        .cmd_valid_i     (cmd_valid),
        .cmd_ready_o     (cmd_ready),
        .cmd_op_i        (cmd_op),
        .cmd_blk_i       (cmd_blk),
        .cmd_mask_i      (cmd_mask),
        .merge_cnt_o     (merge_cnt),
        .fatal_o         (fatal)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_rec(input logic [2:0] b, input logic [1:0] k, input logic [2:0] r);
        exp_q.push_back({b, k, r});
    endtask

    task automatic wait_valid(input string name, input int max);
        int i = 0;
        while (!log_valid && i < max) begin
            tick(1);
            i++;
        end
        check(name, 32'(log_valid), 32'd1);
    endtask

    task automatic wait_drain(input int max);
        int i = 0;
        while ((exp_q.size() != 0 || !cmd_ready) && i < max) begin
            tick(1);
            i++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every accepted record must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && log_valid && log_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_record: got blk=%0d kind=%b rep=%b expected none",
                         log_blk, log_kind, log_rep);
            end else begin
                mon_e = exp_q.pop_front();
                check("log_record", 32'({log_blk, log_kind, log_rep}), 32'(mon_e));
            end
        end
    end

    initial begin
        rst_n = 1'b0; det = '0; corr = '0; brk = '0; log_ready = 1'b0;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_blk = '0; cmd_mask = '0;
        tick(2);
        check("rst_log_valid", 32'(log_valid), 32'd0);
        check("rst_set_broken", 32'(set_brk), 32'd0);
        check("rst_merge_cnt", 32'(merge_cnt), 32'd0);
        check("rst_fatal", 32'(fatal), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        rst_n = 1'b1;
        tick(1);
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // Blocks 0, 5, 7 in one cycle: served 0, 5, 7 from pointer 0.
        log_ready = 1'b1;
        det[0] = 1'b1; corr[0] = 1'b1;
        det[5] = 1'b1;
        brk[7] = 3'b100;
        expect_rec(3'd0, 2'b01, 3'b000);
        expect_rec(3'd5, 2'b10, 3'b000);
        expect_rec(3'd7, 2'b11, 3'b100);
        tick(1);
        det = '0; corr = '0;
        wait_drain(100);
        // Pointer wrapped past 7: block 0 wins over block 6.
        det[6] = 1'b1; det[0] = 1'b1;
        expect_rec(3'd0, 2'b10, 3'b000);
        expect_rec(3'd6, 2'b10, 3'b000);
        tick(1);
        det = '0;
        wait_drain(100);

        // Block 3 corrected: log_valid appears in cycle 3.
        det[3] = 1'b1; corr[3] = 1'b1;
        expect_rec(3'd3, 2'b01, 3'b000);
        tick(1);
        det = '0; corr = '0;
        check("lat_c1", 32'(log_valid), 32'd0);
        tick(1);
        check("lat_c2", 32'(log_valid), 32'd0);
        tick(1);
        check("lat_c3", 32'(log_valid), 32'd1);
        check("lat_blk", 32'(log_blk), 32'd3);
        wait_drain(100);

        // Block 2 breakage held with ready low for 5 cycles, accepted in cycle 8.
        log_ready = 1'b0;
        brk[2] = 3'b010;
        expect_rec(3'd2, 2'b11, 3'b010);
        tick(3);
        check("hold_c3_valid", 32'(log_valid), 32'd1);
        tick(4);
        check("hold_c7_valid", 32'(log_valid), 32'd1);
        check("hold_c7_kind", 32'(log_kind), 32'd3);
        check("hold_c7_rep", 32'(log_rep), 32'd2);
        tick(1);
        log_ready = 1'b1;
        check("hold_c8_valid", 32'(log_valid), 32'd1);
        tick(1);
        check("hold_c9_valid", 32'(log_valid), 32'd0);
        check("single_replica_not_fatal", 32'(fatal), 32'd0);
        wait_drain(100);

        // Block 1 corrected then uncorrected while pending: one kind-10 record.
        det[1] = 1'b1; corr[1] = 1'b1;
        expect_rec(3'd1, 2'b10, 3'b000);
        tick(1);
        corr[1] = 1'b0;
        tick(1);
        det = '0;
        wait_drain(100);
        check("merge_cnt_one", 32'(merge_cnt), 32'd1);

        // Handshake and new event on the presented block in the same cycle.
        log_ready = 1'b0;
        det[4] = 1'b1; corr[4] = 1'b1;
        expect_rec(3'd4, 2'b01, 3'b000);
        expect_rec(3'd4, 2'b10, 3'b000);
        tick(1);
        det = '0; corr = '0;
        wait_valid("hs_evt_valid", 20);
        tick(1);
        log_ready = 1'b1;
        det[4] = 1'b1;
        tick(1);
        det = '0;
        wait_drain(100);
        check("hs_evt_no_merge", 32'(merge_cnt), 32'd1);

        // Config commands: OR masks into block 4, fatal latches, clear keeps fatal.
        check("pre_cmd_fatal", 32'(fatal), 32'd0);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_blk = 3'd4; cmd_mask = 3'b011;
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        tick(1);
        cmd_valid = 1'b0;
        exp_sb = '0;
        exp_sb[4] = 3'b011;
        check("set_broken_011", 32'(set_brk), 32'(exp_sb));
        tick(1);
        check("fatal_set", 32'(fatal), 32'd1);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_mask = 3'b100;
        tick(1);
        cmd_valid = 1'b0;
        exp_sb[4] = 3'b111;
        check("set_broken_or", 32'(set_brk), 32'(exp_sb));
        cmd_valid = 1'b1; cmd_op = 2'b10;
        tick(1);
        cmd_valid = 1'b0;
        check("set_broken_clr", 32'(set_brk), 32'd0);
        tick(1);
        check("fatal_sticky", 32'(fatal), 32'd1);

        // Command while pending in IDLE delays logging; op 11 drops block 6.
        det[5] = 1'b1; corr[5] = 1'b1; det[6] = 1'b1; corr[6] = 1'b1;
        expect_rec(3'd5, 2'b01, 3'b000);
        tick(1);
        det = '0; corr = '0;
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_blk = 3'd6;
        check("cmd_pri_ready", 32'(cmd_ready), 32'd1);
        tick(1);
        cmd_valid = 1'b0;
        check("cmd_pri_c2", 32'(log_valid), 32'd0);
        tick(1);
        check("cmd_pri_c3", 32'(log_valid), 32'd0);
        tick(1);
        check("cmd_pri_c4", 32'(log_valid), 32'd1);
        wait_drain(100);

        // Continuous merging saturates the counter.
        log_ready = 1'b0;
        det[6] = 1'b1; corr[6] = 1'b1;
        expect_rec(3'd6, 2'b01, 3'b000);
        tick(300);
        det = '0; corr = '0;
        check("merge_cnt_sat", 32'(merge_cnt), 32'd255);
        log_ready = 1'b1;
        wait_drain(100);

        // Reset while presenting: record discarded, everything back to zero.
        brk = '0;
        tick(2);
        log_ready = 1'b0;
        det[3] = 1'b1; corr[3] = 1'b1;
        tick(1);
        det = '0; corr = '0;
        wait_valid("rst_mid_valid", 20);
        rst_n = 1'b0;
        tick(1);
        check("rst_mid_valid_drop", 32'(log_valid), 32'd0);
        check("rst_mid_fatal", 32'(fatal), 32'd0);
        check("rst_mid_merge", 32'(merge_cnt), 32'd0);
        rst_n = 1'b1;
        log_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("rst_mid_no_record", 32'(log_valid), 32'd0);
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
